// File: rtl/fifo_btn_ctrl.sv
// Push-button front end for a FIFO: turns debounced write/read levels into
// single-cycle strobes with hold-to-repeat, round-robin arbitration and full/empty error pulses.
module fifo_btn_ctrl #(
  parameter int W        = 8,
  parameter int CW       = 8,
  parameter int HOLD_CYC = 16,
  parameter int REP_CYC  = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         db_wr,
  input  logic         db_rd,
  input  logic [W-1:0] data_sw,
  input  logic         fifo_full,
  input  logic         fifo_empty,
  output logic         wr_en,
  output logic [W-1:0] wr_data,
  output logic         rd_en,
  output logic         err_full,
  output logic         err_empty
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} ch_state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);

  // Channel index 0 is write, 1 is read
  ch_state_t     state_q [2];
  ch_state_t     state_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];
  logic [1:0]    level;
  logic [1:0]    prev_q;
  logic [1:0]    req;
  logic [1:0]    pend_q;
  logic [1:0]    pend_d;
  logic [1:0]    want;
  logic [1:0]    grant;
  logic          last_rd_q;

  assign level = {db_rd, db_wr};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      req[i]     = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (level[i] && !prev_q[i]) begin
            req[i]     = 1'b1;
            cnt_d[i]   = '0;
            state_d[i] = DELAY;
          end
        end
        DELAY: begin
          if (!level[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == HOLD_LAST) begin
            req[i]     = 1'b1;
            cnt_d[i]   = '0;
            state_d[i] = REPEAT;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        REPEAT: begin
          if (!level[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == REP_LAST) begin
            req[i]   = 1'b1;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // On a collision the channel not granted last wins; the loser waits one cycle in pend
  always_comb begin
    want = req | pend_q;
    if (want == 2'b11) begin
      grant = last_rd_q ? 2'b01 : 2'b10;
    end else begin
      grant = want;
    end
    pend_d = want & ~grant;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      prev_q    <= 2'b11;
      pend_q    <= 2'b00;
      last_rd_q <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      prev_q <= level;
      pend_q <= pend_d;
      if (grant[1]) begin
        last_rd_q <= 1'b1;
      end else if (grant[0]) begin
        last_rd_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_en     <= 1'b0;
      wr_data   <= '0;
      rd_en     <= 1'b0;
      err_full  <= 1'b0;
      err_empty <= 1'b0;
    end else begin
      wr_en     <= grant[0] && !fifo_full;
      err_full  <= grant[0] && fifo_full;
      rd_en     <= grant[1] && !fifo_empty;
      err_empty <= grant[1] && fifo_empty;
      if (grant[0] && !fifo_full) begin
        wr_data <= data_sw;
      end
    end
  end

endmodule

// File: doc/fifo_btn_ctrl.md
Name: fifo_btn_ctrl

Overview:
- Sits directly downstream of the button debouncers, between the debounced push-button levels and the FIFO write/read ports.
- Converts the debounced write and read button levels into single-cycle FIFO strobes, with hold-to-auto-repeat.
- Arbitrates write/read collisions round-robin.
- Suppresses strobes the FIFO cannot accept (write when full, read when empty) and flags each with a one-cycle error pulse.

Parameters:
- W, 8: FIFO data width; width of the switch data bus.
- CW, 8: repeat counter width; HOLD_CYC and REP_CYC must be < 2^CW.
- HOLD_CYC, 16: cycles a button is held after its first request before auto-repeat begins.
- REP_CYC, 4: cycles between auto-repeat requests; must be >= 2.

Ports:
- clk, in, 1: system clock, all logic on rising edge.
- n_reset, in, 1: asynchronous active-low reset.
- db_wr, in, 1: debounced write-button level, synchronous to clk.
- db_rd, in, 1: debounced read-button level, synchronous to clk.
- data_sw, in, W: switch data to be written.
- fifo_full, in, 1: FIFO full flag.
- fifo_empty, in, 1: FIFO empty flag.
- wr_en, out, 1: one-cycle FIFO write strobe.
- wr_data, out, W: write data, valid whenever wr_en=1.
- rd_en, out, 1: one-cycle FIFO read strobe.
- err_full, out, 1: one-cycle pulse, write suppressed because FIFO full.
- err_empty, out, 1: one-cycle pulse, read suppressed because FIFO empty.

Behaviour:
- Reset (n_reset=0, asynchronous): wr_en=rd_en=err_full=err_empty=0, wr_data=0, both channel FSMs in IDLE, counters=0, pending flags=0, last-grant=read.
- Reset also sets the prev-level registers to 1, so a button held through reset release issues nothing; it must be released and pressed again.
- Reset asserted mid-operation aborts all pending requests and repeats immediately.
- Per-channel FSM (write and read identical, independent). Each channel has a prev register (last sampled level) and a counter cnt[CW-1:0].
  - IDLE: level=1 and prev=0 → raise request, cnt=0, go to DELAY.
  - DELAY: level=0 → IDLE, no request. Otherwise cnt++; at cnt==HOLD_CYC-1 → request, cnt=0, go to REPEAT.
  - REPEAT: level=0 → IDLE. Otherwise cnt++; at cnt==REP_CYC-1 → request, cnt=0.
- Request timing: with db_wr first sampled 1 at edge k, requests occur at edges k, k+HOLD_CYC, then every REP_CYC cycles. Defaults: k, k+16, k+20, k+24, and so on.
- Arbitration and issue:
  - A request is either served in the same cycle or held in a one-deep pending flag for its channel.
  - With a single contender (new or pending), it is granted.
  - With both contending, the channel not granted last wins and the loser's pending flag is set.
  - Pending is served on the next edge. REP_CYC>=2 guarantees no second request arrives while pending.
  - last-grant updates on every grant.
- Output generation (registered; outputs valid in the cycle after the granting edge, latency 1):
  - Write granted and fifo_full=0: wr_en=1 and wr_data=data_sw sampled at the granting edge.
  - Write granted and fifo_full=1: err_full=1, wr_en=0, wr_data unchanged.
  - Read granted and fifo_empty=0: rd_en=1.
  - Read granted and fifo_empty=1: err_empty=1, rd_en=0.
  - All strobes and error pulses deassert the following cycle unless re-granted.
  - wr_data holds its last written value between writes.
- Full/empty flags are sampled at the granting edge only. A flag change afterwards does not retract an issued strobe.
- Releasing a button while its request is pending still issues the pending request.
- wr_en and rd_en are never high in the same cycle.

Test Plan:
- Reset with db_wr=1 held, release n_reset, hold 10 cycles → no wr_en. Drop db_wr, raise at edge k, data_sw=8'hA5 → wr_en=1 one cycle after edge k, wr_data=8'hA5.
- Hold db_rd for 30 cycles from edge k, fifo_empty=0 → rd_en pulses after edges k, k+16, k+20, k+24, k+28 only. Release → no further pulses.
- db_wr and db_rd rise at the same edge k, last grant=read → wr_en after edge k, rd_en after edge k+1, never simultaneous.
- fifo_full=1, press write → err_full=1 for one cycle, wr_en=0, wr_data unchanged. Same with fifo_empty=1 and read → err_empty pulse, rd_en=0.
- Hold write into repeat, deassert n_reset asynchronously mid-cycle → all outputs 0 immediately. After release with button still held → no strobe until re-press.
- Press write for 5 cycles (< HOLD_CYC) → exactly one wr_en pulse.
